// File: rtl/serdes_pcs_pkg.sv
// Shared PCS TX definitions: idle_b pattern, scrambler polynomial taps, TX FSM states.
package serdes_pcs_pkg;

  localparam int unsigned LANE_WIDTH = 62;
  localparam int unsigned POLY_WIDTH = 58;
  localparam int unsigned TAP_A      = 38;
  localparam int unsigned TAP_B      = 57;

  // MSB of the literal lands on index 0, the first bit on the wire.
  localparam logic [0:LANE_WIDTH-1] IDLE_B_WORD = {6'h2C, {7{8'hBC}}};

  typedef enum logic [0:0] {
    TRAIN,
    DATA
  } tx_state_t;

endpackage

// File: rtl/scr_lfsr_step.sv
// One lane word through the self-synchronising scrambler G(x) = x^58 + x^39 + 1,
// bit 0 first. Purely combinational; the caller registers word_out and lfsr_out.
module scr_lfsr_step
  import serdes_pcs_pkg::*;
(
  input  logic [0:LANE_WIDTH-1]   word,
  input  logic [POLY_WIDTH-1:0]   lfsr_in,
  input  logic                    bypass,
  output logic [0:LANE_WIDTH-1]   word_out,
  output logic [POLY_WIDTH-1:0]   lfsr_out
);

  logic [POLY_WIDTH-1:0] lfsr_v;
  logic                  bit_v;

  // Unrolled per-bit scramble; the register always absorbs the emitted bit, even in bypass.
  always_comb begin
    lfsr_v   = lfsr_in;
    bit_v    = 1'b0;
    word_out = '0;
    for (int unsigned i = 0; i < LANE_WIDTH; i++) begin
      bit_v       = bypass ? word[i] : (word[i] ^ lfsr_v[TAP_A] ^ lfsr_v[TAP_B]);
      word_out[i] = bit_v;
      lfsr_v      = {lfsr_v[POLY_WIDTH-2:0], bit_v};
    end
    lfsr_out = lfsr_v;
  end

endmodule

// File: rtl/scrambler_tx.sv
// TX PCS scrambler: training-burst FSM, idle_b insertion, one output register stage.
// Optional feature: define SCRAMBLER_BYPASS_EN to add the scrambler_bypass input.
module scrambler_tx
  import serdes_pcs_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 62,
  parameter int unsigned TRAIN_WORDS = 16
) (
  input  logic                  clk_390p625M,
  input  logic                  rst,
`ifdef SCRAMBLER_BYPASS_EN
  input  logic                  scrambler_bypass,
`endif
  input  logic [0:DATA_WIDTH-1] data_in,
  input  logic                  data_in_valid,
  output logic                  data_in_ready,
  input  logic                  train_req,
  output logic [0:DATA_WIDTH-1] scrambled_data_out,
  output logic                  scrambled_valid,
  output logic                  tx_link_up
);

  localparam logic [15:0] TRAIN_LOAD = 16'(TRAIN_WORDS);

  tx_state_t              state_q, state_d;
  logic [15:0]            cnt_q, cnt_d, cnt_eff;
  logic [POLY_WIDTH-1:0]  lfsr_q, lfsr_d;
  logic [0:DATA_WIDTH-1]  out_q, out_d;
  logic                   valid_q, valid_d;
  logic                   link_q, link_d;
  logic [0:DATA_WIDTH-1]  word_sel;
  logic                   bypass_w;

`ifdef SCRAMBLER_BYPASS_EN
  assign bypass_w = scrambler_bypass;
`else
  assign bypass_w = 1'b0;
`endif

  assign data_in_ready      = (state_q == DATA);
  assign scrambled_data_out = out_q;
  assign scrambled_valid    = valid_q;
  assign tx_link_up         = link_q;

  scr_lfsr_step u_step (
    .word     (word_sel),
    .lfsr_in  (lfsr_q),
    .bypass   (bypass_w),
    .word_out (out_d),
    .lfsr_out (lfsr_d)
  );

  // Next-state, counter and word select.
  // A train_req in TRAIN restarts the burst with the current idle word as its first word,
  // so the count is reloaded and decremented on the same edge.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cnt_eff  = cnt_q;
    word_sel = IDLE_B_WORD;
    case (state_q)
      TRAIN: begin
        cnt_eff = train_req ? TRAIN_LOAD : cnt_q;
        if (cnt_eff == 16'd1) begin
          state_d = DATA;
          cnt_d   = TRAIN_LOAD;
        end else begin
          cnt_d = cnt_eff - 16'd1;
        end
      end
      DATA: begin
        if (data_in_valid) word_sel = data_in;
        if (train_req) begin
          state_d = TRAIN;
          cnt_d   = TRAIN_LOAD;
        end
      end
      default: begin
        state_d = TRAIN;
        cnt_d   = TRAIN_LOAD;
      end
    endcase
    valid_d = 1'b1;
    link_d  = (state_d == DATA);
  end

  // State and counter registers.
  always_ff @(posedge clk_390p625M or posedge rst) begin
    if (rst) begin
      state_q <= TRAIN;
      cnt_q   <= TRAIN_LOAD;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Output word, LFSR and status registers.
  always_ff @(posedge clk_390p625M or posedge rst) begin
    if (rst) begin
      lfsr_q  <= '1;
      out_q   <= '0;
      valid_q <= 1'b0;
      link_q  <= 1'b0;
    end else begin
      lfsr_q  <= lfsr_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      link_q  <= link_d;
    end
  end

endmodule

// File: tb/tb_scrambler_tx.sv
`timescale 1ns/1ps
module tb_scrambler_tx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [0:61] data_in = '0;
  logic        data_in_valid = 1'b0;
  logic        train_req = 1'b0;
  logic        bypass = 1'b0;

  logic [0:61] out_w [3];
  logic        val_w [3];
  logic        rdy_w [3];
  logic        lnk_w [3];

  int checks = 0;
  int failures = 0;

  logic [0:61] idle_v;

  // Reference state per instance: link flag, idle words left, last 58 wire bits.
  bit          m_link [3];
  int          left   [3];
  logic [57:0] h      [3];
  logic [0:61] exp_pt [3];
  logic [0:61] got_pt [3];
  logic [0:61] raw_w  [3];
  logic        pre_rdy[3];
  logic        exp_rdy[3];

  always #5 clk = ~clk;

  scrambler_tx #(.DATA_WIDTH(62), .TRAIN_WORDS(4)) dut_a (
    .clk_390p625M(clk), .rst(rst),
`ifdef SCRAMBLER_BYPASS_EN
    .scrambler_bypass(bypass),
`endif
    .data_in(data_in), .data_in_valid(data_in_valid), .data_in_ready(rdy_w[0]),
    .train_req(train_req), .scrambled_data_out(out_w[0]), .scrambled_valid(val_w[0]),
    .tx_link_up(lnk_w[0]));

  scrambler_tx #(.DATA_WIDTH(62), .TRAIN_WORDS(16)) dut_b (
    .clk_390p625M(clk), .rst(rst),
`ifdef SCRAMBLER_BYPASS_EN
    .scrambler_bypass(bypass),
`endif
    .data_in(data_in), .data_in_valid(data_in_valid), .data_in_ready(rdy_w[1]),
    .train_req(train_req), .scrambled_data_out(out_w[1]), .scrambled_valid(val_w[1]),
    .tx_link_up(lnk_w[1]));

  scrambler_tx #(.DATA_WIDTH(62), .TRAIN_WORDS(1)) dut_c (
    .clk_390p625M(clk), .rst(rst),
`ifdef SCRAMBLER_BYPASS_EN
    .scrambler_bypass(bypass),
`endif
    .data_in(data_in), .data_in_valid(data_in_valid), .data_in_ready(rdy_w[2]),
    .train_req(train_req), .scrambled_data_out(out_w[2]), .scrambled_valid(val_w[2]),
    .tx_link_up(lnk_w[2]));

  function automatic int tw(int k);
    case (k)
      0: return 4;
      1: return 16;
      default: return 1;
    endcase
  endfunction

  function automatic logic [0:61] rnd62();
    return 62'({$urandom(), $urandom()});
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_link[k] = 1'b0;
      left[k]   = tw(k);
      h[k]      = '1;
    end
  endtask

  // Advance one edge: predict plaintext per instance, then descramble what came out.
  task automatic step();
    logic bp;
    logic p;
    bp = bypass;
    for (int k = 0; k < 3; k++) begin
      pre_rdy[k] = rdy_w[k];
      exp_rdy[k] = m_link[k];
      exp_pt[k]  = (m_link[k] && data_in_valid) ? data_in : idle_v;
      if (!m_link[k]) begin
        if (train_req) left[k] = tw(k);
        left[k] = left[k] - 1;
        if (left[k] == 0) m_link[k] = 1'b1;
      end else if (train_req) begin
        m_link[k] = 1'b0;
        left[k]   = tw(k);
      end
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      raw_w[k] = out_w[k];
      for (int i = 0; i < 62; i++) begin
        p = raw_w[k][i] ^ h[k][38] ^ h[k][57];
        got_pt[k][i] = bp ? raw_w[k][i] : p;
        h[k] = {h[k][56:0], raw_w[k][i]};
      end
    end
  endtask

  task automatic test_reset();
    logic [0:38] pre_g;
    logic [0:38] pre_e;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      checks++; if (out_w[k] !== 62'h0) begin failures++; $display("FAIL reset_out k=%0d got=%h exp=0", k, out_w[k]); end
      checks++; if (val_w[k] !== 1'b0) begin failures++; $display("FAIL reset_valid k=%0d got=%b exp=0", k, val_w[k]); end
      checks++; if (lnk_w[k] !== 1'b0) begin failures++; $display("FAIL reset_link k=%0d got=%b exp=0", k, lnk_w[k]); end
      checks++; if (rdy_w[k] !== 1'b0) begin failures++; $display("FAIL reset_ready k=%0d got=%b exp=0", k, rdy_w[k]); end
    end
    rst = 1'b0;
    model_reset();
    data_in_valid = 1'b1;
    for (int n = 1; n <= 4; n++) begin
      data_in = rnd62();
      step();
      checks++; if (got_pt[0] !== idle_v) begin failures++; $display("FAIL train_word n=%0d got=%h exp=%h", n, got_pt[0], idle_v); end
      checks++; if (val_w[0] !== 1'b1) begin failures++; $display("FAIL train_valid n=%0d got=%b exp=1", n, val_w[0]); end
      checks++; if (lnk_w[0] !== (n == 4)) begin failures++; $display("FAIL train_link n=%0d got=%b exp=%b", n, lnk_w[0], n == 4); end
      checks++; if (pre_rdy[0] !== 1'b0) begin failures++; $display("FAIL train_ready n=%0d got=%b exp=0", n, pre_rdy[0]); end
      if (n == 1) begin
        pre_g = raw_w[0][0:38];
        pre_e = idle_v[0:38];
        checks++; if (pre_g !== pre_e) begin failures++; $display("FAIL seed_cancel got=%h exp=%h", pre_g, pre_e); end
        checks++; if (lnk_w[2] !== 1'b1) begin failures++; $display("FAIL tw1_link got=%b exp=1", lnk_w[2]); end
        checks++; if (got_pt[2] !== idle_v) begin failures++; $display("FAIL tw1_word got=%h exp=%h", got_pt[2], idle_v); end
      end
    end
    checks++; if (rdy_w[0] !== 1'b1) begin failures++; $display("FAIL train_done_ready got=%b exp=1", rdy_w[0]); end
  endtask

  task automatic test_zero_payload();
    data_in_valid = 1'b1;
    data_in = '0;
    for (int n = 0; n < 10; n++) begin
      step();
      checks++; if (got_pt[0] !== 62'h0) begin failures++; $display("FAIL zero_word n=%0d got=%h exp=0", n, got_pt[0]); end
      checks++; if (pre_rdy[0] !== 1'b1) begin failures++; $display("FAIL zero_ready n=%0d got=%b exp=1", n, pre_rdy[0]); end
    end
  endtask

  task automatic test_valid_toggle();
    logic [0:61] a;
    logic [0:61] b;
    a = rnd62();
    b = rnd62();
    data_in_valid = 1'b1; data_in = a; step();
    checks++; if (got_pt[0] !== a) begin failures++; $display("FAIL toggle_a got=%h exp=%h", got_pt[0], a); end
    data_in_valid = 1'b0; data_in = rnd62(); step();
    checks++; if (got_pt[0] !== idle_v) begin failures++; $display("FAIL toggle_idle got=%h exp=%h", got_pt[0], idle_v); end
    data_in_valid = 1'b1; data_in = b; step();
    checks++; if (got_pt[0] !== b) begin failures++; $display("FAIL toggle_b got=%h exp=%h", got_pt[0], b); end
  endtask

  task automatic test_train_req_data();
    logic [0:61] c;
    int n;
    data_in_valid = 1'b0;
    n = 0;
    while (rdy_w[1] !== 1'b1 && n < 40) begin step(); n++; end
    checks++; if (rdy_w[1] !== 1'b1) begin failures++; $display("FAIL wait_data got=%b exp=1", rdy_w[1]); end
    c = rnd62();
    data_in_valid = 1'b1; data_in = c; train_req = 1'b1;
    step();
    train_req = 1'b0;
    checks++; if (got_pt[1] !== c) begin failures++; $display("FAIL req_word got=%h exp=%h", got_pt[1], c); end
    checks++; if (rdy_w[1] !== 1'b0) begin failures++; $display("FAIL req_ready got=%b exp=0", rdy_w[1]); end
    checks++; if (lnk_w[1] !== 1'b0) begin failures++; $display("FAIL req_link got=%b exp=0", lnk_w[1]); end
    for (int i = 0; i < 16; i++) begin
      data_in = rnd62();
      step();
      checks++; if (got_pt[1] !== idle_v) begin failures++; $display("FAIL reburst_word i=%0d got=%h exp=%h", i, got_pt[1], idle_v); end
    end
    checks++; if (lnk_w[1] !== 1'b1) begin failures++; $display("FAIL reburst_link got=%b exp=1", lnk_w[1]); end
    c = rnd62();
    data_in = c;
    step();
    checks++; if (got_pt[1] !== c) begin failures++; $display("FAIL reburst_data got=%h exp=%h", got_pt[1], c); end
  endtask

  task automatic test_train_restart();
    int run;
    int n;
    train_req = 1'b1; data_in_valid = 1'b0;
    step();
    train_req = 1'b0; data_in_valid = 1'b1;
    run = 0;
    for (int i = 0; i < 14; i++) begin
      data_in = rnd62();
      step();
      if (pre_rdy[1] === 1'b0) run++;
      checks++; if (got_pt[1] !== idle_v) begin failures++; $display("FAIL restart_pre i=%0d got=%h exp=%h", i, got_pt[1], idle_v); end
    end
    train_req = 1'b1;
    step();
    if (pre_rdy[1] === 1'b0) run++;
    train_req = 1'b0;
    n = 0;
    while (rdy_w[1] !== 1'b1 && n < 40) begin
      data_in = rnd62();
      step();
      n++;
      if (pre_rdy[1] === 1'b0) run++;
      checks++; if (got_pt[1] !== idle_v) begin failures++; $display("FAIL restart_post n=%0d got=%h exp=%h", n, got_pt[1], idle_v); end
    end
    checks++; if (rdy_w[1] !== 1'b1) begin failures++; $display("FAIL restart_timeout got=%b exp=1", rdy_w[1]); end
    checks++; if (run !== 30) begin failures++; $display("FAIL restart_run got=%0d exp=30", run); end
  endtask

  task automatic test_reset_mid_data();
    logic [0:38] pre_g;
    logic [0:38] pre_e;
    int n;
    data_in_valid = 1'b1; data_in = rnd62();
    step();
    #2;
    rst = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      checks++; if (out_w[k] !== 62'h0) begin failures++; $display("FAIL async_out k=%0d got=%h exp=0", k, out_w[k]); end
      checks++; if (val_w[k] !== 1'b0) begin failures++; $display("FAIL async_valid k=%0d got=%b exp=0", k, val_w[k]); end
      checks++; if (lnk_w[k] !== 1'b0) begin failures++; $display("FAIL async_link k=%0d got=%b exp=0", k, lnk_w[k]); end
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    data_in = rnd62();
    step();
    pre_g = raw_w[0][0:38];
    pre_e = idle_v[0:38];
    checks++; if (pre_g !== pre_e) begin failures++; $display("FAIL reseed got=%h exp=%h", pre_g, pre_e); end
    checks++; if (got_pt[0] !== idle_v) begin failures++; $display("FAIL reseed_word got=%h exp=%h", got_pt[0], idle_v); end
`ifdef SCRAMBLER_BYPASS_EN
    n = 0;
    while (rdy_w[0] !== 1'b1 && n < 10) begin step(); n++; end
    checks++; if (rdy_w[0] !== 1'b1) begin failures++; $display("FAIL bypass_wait got=%b exp=1", rdy_w[0]); end
    bypass = 1'b1;
    for (int i = 0; i < 4; i++) begin
      data_in = rnd62();
      step();
      checks++; if (raw_w[0] !== data_in) begin failures++; $display("FAIL bypass_word i=%0d got=%h exp=%h", i, raw_w[0], data_in); end
    end
    bypass = 1'b0;
`else
    n = 0;
`endif
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 300; n++) begin
      data_in_valid = ($urandom() % 2) == 0;
      data_in       = rnd62();
      train_req     = ($urandom() % 25) == 0;
      step();
      for (int k = 0; k < 3; k++) begin
        checks++; if (got_pt[k] !== exp_pt[k]) begin failures++; $display("FAIL b2b_word n=%0d k=%0d got=%h exp=%h", n, k, got_pt[k], exp_pt[k]); end
        checks++; if (lnk_w[k] !== m_link[k]) begin failures++; $display("FAIL b2b_link n=%0d k=%0d got=%b exp=%b", n, k, lnk_w[k], m_link[k]); end
        checks++; if (pre_rdy[k] !== exp_rdy[k]) begin failures++; $display("FAIL b2b_ready n=%0d k=%0d got=%b exp=%b", n, k, pre_rdy[k], exp_rdy[k]); end
        checks++; if (val_w[k] !== 1'b1) begin failures++; $display("FAIL b2b_valid n=%0d k=%0d got=%b exp=1", n, k, val_w[k]); end
      end
    end
    train_req = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle_v = {6'h2C, {7{8'hBC}}};
    model_reset();
    test_reset();
    test_zero_payload();
    test_valid_toggle();
    test_train_req_data();
    test_train_restart();
    test_reset_mid_data();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
